// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit feeding HI/LO for MFHI/MFLO; one step per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiplies whose |B| fits in WIDTH/2 bits finish in WIDTH/2 steps.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result_hi,
    output logic [WIDTH-1:0] Result_lo,
    output logic             DivByZero
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned DW   = 2 * WIDTH;

    typedef enum logic [1:0] { IDLE, CALC, DONE } state_t;
    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_cnt;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    acc_step;
    logic [DW-1:0]    prod;
    logic [DW-1:0]    prod_signed;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             borrow;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             early;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             load;
    logic             finish;

    // Signed ops run on magnitudes; signs are re-applied when the result is written.
    assign a_neg    = ~Op[0] & A[WIDTH-1];
    assign b_neg    = ~Op[0] & B[WIDTH-1];
    assign a_mag    = a_neg ? WIDTH'(0) - A : A;
    assign b_mag    = b_neg ? WIDTH'(0) - B : B;
    assign div_zero = Op[1] & (B == '0);
    assign last_cnt = early ? CNT_W'(HALF - 1) : CNT_W'(WIDTH - 1);

    // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    assign mul_sum   = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
    assign rem_shift = {acc[DW-1:WIDTH], acc[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd};
    assign borrow    = ~rem_shift[WIDTH] & rem_diff[WIDTH];

    assign acc_step = !is_div ? {mul_sum, acc[WIDTH-1:1]}
                    : borrow  ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                    :           {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // A shortened multiply leaves the product WIDTH/2 bits too high in acc.
    assign prod        = early ? (acc_step >> HALF) : acc_step;
    assign prod_signed = neg_q ? DW'(0) - prod : prod;
    assign quo         = neg_q ? WIDTH'(0) - acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    assign rem         = neg_r ? WIDTH'(0) - acc_step[DW-1:WIDTH] : acc_step[DW-1:WIDTH];

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    load       = 1'b1;
                    state_next = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == last_cnt) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        // flush overrides everything, including a same-edge start
        if (flush) begin
            state_next = IDLE;
            load       = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == CALC);
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            Result_hi <= '0;
            Result_lo <= '0;
            DivByZero <= 1'b0;
        end else begin
            if (load) begin
                cnt    <= '0;
                opnd   <= Op[1] ? b_mag : a_mag;
                acc    <= {WIDTH'(0), (Op[1] ? a_mag : b_mag)};
                is_div <= Op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
                acc <= acc_step;
            end

            if (load && div_zero) begin
                Result_hi <= A;
                Result_lo <= '1;
                DivByZero <= 1'b1;
            end else if (finish) begin
                Result_hi <= is_div ? rem : prod_signed[DW-1:WIDTH];
                Result_lo <= is_div ? quo : prod_signed[WIDTH-1:0];
                DivByZero <= 1'b0;
            end
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Upper multiplier half is zero: the remaining steps would only shift acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            early <= 1'b0;
        else if (load)
            early <= ~Op[1] & (b_mag[WIDTH-1:HALF] == '0);
    end
`else
    assign early = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences and random ops vs a plain-arithmetic model.
module tb_muldiv_unit;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LS = 16;
`else
    localparam int LS = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        DivByZero;
    logic [31:0] Result_hi;
    logic [31:0] Result_lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Op(Op), .A(A), .B(B),
        .flush(flush), .busy(busy), .done(done), .Result_hi(Result_hi),
        .Result_lo(Result_lo), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {DivByZero, hi, lo} from plain integer arithmetic
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model = '0;
        if (op == 2'b00) begin
            p = 64'(sa * sb);
            model = {1'b0, p};
        end else if (op == 2'b01) begin
            p = {32'd0, a} * {32'd0, b};
            model = {1'b0, p};
        end else if (b == 32'd0) begin
            model = {1'b1, a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
            model = {1'b0, r[31:0], q[31:0]};
        end else begin
            model = {1'b0, a % b, a / b};
        end
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        if (op[1]) return (b == 32'd0) ? 0 : 32;
`ifdef MULDIV_EARLY_OUT_EN
        begin
            logic [31:0] mag;
            mag = (op == 2'b00 && b[31]) ? 32'd0 - b : b;
            if (mag < 32'h0001_0000) return 16;
        end
`endif
        return 32;
    endfunction

    // Issue one op (time is just after an edge), wait for done, compare everything.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input logic dbz, input int lat);
        int n;
        int busy_low;
        start = 1'b1; Op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; Op = 2'($urandom_range(0, 3)); A = $urandom; B = $urandom;
        n = 0;
        busy_low = 0;
        while (!done && n <= 40) begin
            if (!busy) busy_low++;
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s_latency", tag), 64'(n), 64'(lat));
        check($sformatf("%s_busy_low", tag), 64'(busy_low), 64'd0);
        check($sformatf("%s_busy_at_done", tag), 64'(busy), 64'd0);
        check($sformatf("%s_hi", tag), 64'(Result_hi), 64'(hi));
        check($sformatf("%s_lo", tag), 64'(Result_lo), 64'(lo));
        check($sformatf("%s_dbz", tag), 64'(DivByZero), 64'(dbz));
    endtask

    task automatic idle_check(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        @(posedge clk); #1;
        check($sformatf("%s_done_drop", tag), 64'(done), 64'd0);
        check($sformatf("%s_busy_idle", tag), 64'(busy), 64'd0);
        check($sformatf("%s_hold_hi", tag), 64'(Result_hi), 64'(hi));
        check($sformatf("%s_hold_lo", tag), 64'(Result_lo), 64'(lo));
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check($sformatf("%s_no_activity", tag), 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        logic [64:0] m;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LS};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32};
        vecs[3]  = '{2'b11, 32'd100,       32'd7,          32'd2,         32'd14,        1'b0, 32};
        vecs[4]  = '{2'b11, 32'd100,       32'd0,          32'd100,       32'hFFFF_FFFF, 1'b1, 0};
        vecs[5]  = '{2'b01, 32'd2,         32'd3,          32'd0,         32'd6,         1'b0, LS};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 32};
        vecs[7]  = '{2'b01, 32'h1234_5678, 32'h10,         32'h0000_0001, 32'h2345_6780, 1'b0, LS};
        vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 32};
        vecs[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 32};
        vecs[10] = '{2'b10, 32'd0,         32'd5,          32'd0,         32'd0,         1'b0, 32};
        vecs[11] = '{2'b00, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LS};
        vecs[12] = '{2'b11, 32'hFFFF_FFFF, 32'd16,         32'hF,         32'h0FFF_FFFF, 1'b0, 32};
        vecs[13] = '{2'b10, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0};
        vecs[14] = '{2'b00, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LS};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; Op = 2'b00; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(Result_hi), 64'd0);
        check("rst_lo", 64'(Result_lo), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back: each op is issued in the done cycle of the previous one
        for (int i = 0; i < 15; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);
        idle_check("vec_end", vecs[14].hi, vecs[14].lo);

        // start while in CALC is ignored, not queued
        start = 1'b1; Op = 2'b01; A = 32'h0001_0000; B = 32'h0001_0000;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (5) begin @(posedge clk); #1; n++; end
        start = 1'b1; Op = 2'b11; A = 32'd1; B = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; n++;
        while (!done && n <= 40) begin @(posedge clk); #1; n++; end
        check("ign_latency", 64'(n), 64'd32);
        check("ign_hi", 64'(Result_hi), 64'd1);
        check("ign_lo", 64'(Result_lo), 64'd0);
        check("ign_dbz", 64'(DivByZero), 64'd0);
        idle_check("ign", 32'd1, 32'd0);

        // flush mid-operation: no done, results untouched
        do_op("pre_flush", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, LS);
        @(posedge clk); #1;
        start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(Result_hi), 64'd0);
        check("flush_lo", 64'(Result_lo), 64'd6);
        count_dones("flush", 40);

        // flush and start on the same edge: start dropped
        flush = 1'b1; start = 1'b1; Op = 2'b01; A = 32'd7; B = 32'd7;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        count_dones("flush_start", 40);
        check("flush_start_lo", 64'(Result_lo), 64'd6);

        // asynchronous reset mid-operation
        start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(Result_hi), 64'd0);
        check("arst_lo", 64'(Result_lo), 64'd0);
        check("arst_dbz", 64'(DivByZero), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_dones("arst", 40);

        // random ops against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'($urandom_range(0, 65535));
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: b = 32'd0 - 32'($urandom_range(1, 1000));
                default: ;
            endcase
            m = model(op, a, b);
            do_op($sformatf("rnd%0d", i), op, a, b, m[63:32], m[31:0], m[64], exp_lat(op, b));
            if ($urandom_range(0, 1) == 1)
                idle_check($sformatf("rnd%0d", i), m[63:32], m[31:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit integer multiply/divide unit in the EX stage, in parallel with the ALU.
- Operands A and B come from the same ID/EX operand muxes that feed the ALU.
- Produces a 64-bit product, or a quotient and remainder, into HI/LO for later MFHI/MFLO.
- Drives busy to the hazard unit; the pipeline stalls any MFHI/MFLO or new mul/div while busy is high.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled on rising edge
- Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- flush  input  1  synchronous abort from branch/exception logic
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: Result_hi/Result_lo just updated
- Result_hi  output  WIDTH  product[63:32] or remainder
- Result_lo  output  WIDTH  product[31:0] or quotient
- DivByZero  output  1  last completed operation was a divide with B==0

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy=0, done=0, DivByZero=0, Result_hi=0, Result_lo=0; counter and internal registers cleared. Reset mid-operation abandons the op with no done pulse.
- States:
  - IDLE: start=1 latches Op, A, B and goes to CALC. If Op is a divide and B==0, goes to DONE instead.
  - CALC: busy=1. Performs one radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide.
  - CALC exits after exactly WIDTH cycles (counter 0..WIDTH-1), going to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Result_hi/Result_lo and DivByZero are registered on entry to DONE.
  - From DONE: start=1 accepts a new op (back-to-back); otherwise go to IDLE.
- Latency: acceptance edge to the edge that asserts done = WIDTH cycles (32). Divide-by-zero: 1 cycle.
- start while in CALC is ignored; the op is not queued.
- Results hold their value until the next DONE entry or reset.
- Signed ops:
  - Operate on magnitudes; apply sign correction at completion.
  - Product sign = sign(A) XOR sign(B).
  - Quotient truncates toward zero; remainder takes the sign of A.
- -2^31 / -1: quotient=0x80000000, remainder=0, DivByZero=0.
- Divide by zero: Result_lo=0xFFFFFFFF, Result_hi=A, DivByZero=1. DivByZero is cleared by the next completed op.
- flush:
  - Sampled each edge; in any state, forces IDLE next cycle with no done pulse.
  - Results stay unchanged.
  - flush and start on the same edge: flush wins, start is dropped.
- Width rules: multiply accumulates into a 2*WIDTH register. Divide uses a WIDTH+1 partial remainder so the subtract borrow is explicit.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: for MULT/MULTU, if |B|[WIDTH-1:WIDTH/2]==0 at acceptance, CALC runs WIDTH/2 cycles (16) instead of WIDTH. Results are identical. Divide latency is unchanged.
- Not defined: all ops take exactly WIDTH cycles.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=7 -> after 32 cycles done=1 for 1 cycle; Result_hi=0xFFFFFFFF, Result_lo=0xFFFFFFEB; busy high for cycles 1..32.
- MULTU, A=B=0xFFFFFFFF -> Result_hi=0xFFFFFFFE, Result_lo=0x00000001.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> Result_lo=0xFFFFFFFD, Result_hi=0xFFFFFFFF, DivByZero=0. Then DIVU A=100, B=7 issued on the done cycle -> accepted back-to-back; Result_lo=14, Result_hi=2.
- DIVU, A=100, B=0 -> done one cycle after start; Result_lo=0xFFFFFFFF, Result_hi=100, DivByZero=1. Next MULTU 2*3 clears DivByZero; Result_lo=6.
- MULT 5*5 started; flush asserted at cycle 10 -> IDLE next cycle, no done pulse, results keep the prior values. A repeat of this run with rst_n pulsed low at cycle 10 instead -> all outputs 0 immediately.
- With MULDIV_EARLY_OUT_EN: MULTU A=0x12345678, B=0x10 -> done after 16 cycles, Result_lo=0x23456780, Result_hi=0x00000001. Without the macro: same results after 32 cycles.
